// File: rtl/poly_inverse.sv
// poly_inverse: inverse of the board's quadratic evaluator.
// Loads A, B, C and target Y one operand per go press, then searches
// x = 0 .. 2^WIDTH-1 for the smallest x with (A*x^2 + B*x + C) mod 2^WIDTH == Y.
// The polynomial is stepped with forward differences, so no multiplier is used.
//
// Ports:
//   clk       system clock
//   resetn    synchronous, active-low reset (aborts any search in progress)
//   go        level, active-high; advances the operand-load sequence
//   data_in   operand value (switches)
//   x_result  smallest root found, 0 if none
//   found     1 = x_result is a valid root of the last search
//   done      1 = last search completed, result outputs valid
//   busy      1 while initialising or searching
module poly_inverse #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] x_result,
  output logic             found,
  output logic             done,
  output logic             busy
);

  typedef enum logic [3:0] {
    LOAD_A,
    LOAD_A_WAIT,
    LOAD_B,
    LOAD_B_WAIT,
    LOAD_C,
    LOAD_C_WAIT,
    LOAD_Y,
    LOAD_Y_WAIT,
    INIT,
    SEARCH
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a, b, c, y;
  logic [WIDTH-1:0] x;  // current candidate
  logic [WIDTH-1:0] f;  // poly(x) mod 2^WIDTH
  logic [WIDTH-1:0] d;  // poly(x+1) - poly(x) = 2Ax + A + B

  logic hit, last;
  assign hit  = (f == y);
  assign last = (x == '1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= LOAD_A;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_A:      if (go)  state_nxt = LOAD_A_WAIT;
      LOAD_A_WAIT: if (!go) state_nxt = LOAD_B;
      LOAD_B:      if (go)  state_nxt = LOAD_B_WAIT;
      LOAD_B_WAIT: if (!go) state_nxt = LOAD_C;
      LOAD_C:      if (go)  state_nxt = LOAD_C_WAIT;
      LOAD_C_WAIT: if (!go) state_nxt = LOAD_Y;
      LOAD_Y:      if (go)  state_nxt = LOAD_Y_WAIT;
      LOAD_Y_WAIT: if (!go) state_nxt = INIT;
      INIT:        state_nxt = SEARCH;
      SEARCH:      if (hit || last) state_nxt = LOAD_A;
      default:     state_nxt = LOAD_A;
    endcase
  end

  assign busy = (state == INIT) || (state == SEARCH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      y        <= '0;
      x        <= '0;
      f        <= '0;
      d        <= '0;
      x_result <= '0;
      found    <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: a <= data_in;
        LOAD_B: b <= data_in;
        LOAD_C: c <= data_in;
        LOAD_Y: y <= data_in;
        INIT: begin
          x        <= '0;
          f        <= c;
          d        <= a + b;
          x_result <= '0;
          found    <= 1'b0;
          done     <= 1'b0;
        end
        SEARCH: begin
          // A hit is tested before the end-of-range exit so the last
          // candidate is still considered.
          if (hit) begin
            x_result <= x;
            found    <= 1'b1;
            done     <= 1'b1;
          end else if (last) begin
            x_result <= '0;
            found    <= 1'b0;
            done     <= 1'b1;
          end else begin
            x <= x + 1'b1;
            f <= f + d;
            d <= d + {a[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_inverse.sv
module tb_poly_inverse;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] x_result;
  logic       found, done, busy;

  int checks = 0;
  int errors = 0;
  bit exp_done_hold = 1'b0;

  poly_inverse #(.WIDTH(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .go       (go),
    .data_in  (data_in),
    .x_result (x_result),
    .found    (found),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Brute-force reference: evaluate the polynomial for every x mod 256.
  task automatic model(input int a, input int b, input int c, input int y,
                       output bit f, output int xr, output int lat);
    f = 1'b0; xr = 0; lat = 257;
    for (int x = 0; x < 256; x++) begin
      if (!f && (((a * x * x) + (b * x) + c) % 256) == y) begin
        f = 1'b1; xr = x; lat = 2 + x;
      end
    end
  endtask

  task automatic load_op(input logic [7:0] v, input int hold, input bit scramble);
    @(negedge clk);
    data_in = v;
    go = 1'b1;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (scramble) data_in = 8'($urandom);
    end
    @(negedge clk);
    go = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic run_search(input bit toggle, output int lat);
    lat = -1;
    @(posedge clk);  // INIT entry edge
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_init got %b want 1", busy);
    end
    for (int i = 1; i <= 300 && lat < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) lat = i;
      else if (toggle) go = 1'($urandom);
    end
    go = 1'b0;
  endtask

  task automatic do_search(input string name, input int a, input int b, input int c,
                           input int y, input int hold, input bit scramble, input bit toggle);
    bit ef; int ex, el, lat;
    model(a, b, c, y, ef, ex, el);
    load_op(8'(a), hold, scramble);
    load_op(8'(b), hold, scramble);
    load_op(8'(c), hold, scramble);
    load_op(8'(y), hold, scramble);
    checks++;
    if (done !== exp_done_hold) begin
      errors++;
      $display("FAIL %s done_hold got %b want %b", name, done, exp_done_hold);
    end
    run_search(toggle, lat);
    checks++;
    if (lat != el) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, el);
    end
    checks++;
    if (found !== ef || x_result !== 8'(ex)) begin
      errors++;
      $display("FAIL %s result got found=%b x=%0d want found=%b x=%0d",
               name, found, x_result, ef, ex);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got %b want 0", name, busy);
    end
    exp_done_hold = 1'b1;
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || x_result !== 8'd0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b found=%b x=%0d want all 0",
               name, busy, done, found, x_result);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    resetn = 1'b1;
    exp_done_hold = 1'b0;
  endtask

  task automatic test_basic();
    do_search("basic_a1b2c3y11", 1, 2, 3, 11, 1, 0, 0);
    do_search("const_hit_x0", 0, 0, 5, 5, 1, 0, 0);
    do_search("no_root", 0, 0, 5, 6, 1, 0, 0);
  endtask

  task automatic test_boundary();
    do_search("last_candidate", 0, 1, 0, 255, 1, 0, 0);
    do_search("even_only", 0, 2, 0, 1, 1, 0, 0);
  endtask

  task automatic test_wrap();
    do_search("wrap_a16", 16, 0, 0, 0, 1, 0, 0);
    do_search("wrap_a16c1", 16, 0, 1, 17, 1, 0, 0);
    do_search("wrap_b255", 1, 255, 0, 0, 1, 0, 0);
    do_search("wrap_a2y8", 2, 0, 0, 8, 1, 0, 0);
  endtask

  task automatic test_handshake();
    do_search("hold_go_50", 3, 7, 11, 100, 50, 1, 0);
    do_search("go_toggle_search", 1, 2, 3, 11, 1, 0, 1);
    do_search("go_toggle_noroot", 0, 2, 0, 1, 2, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int a, b, c, y;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      // Half the targets are chosen from the polynomial's range to ensure hits.
      if (n % 2 == 0) begin
        int xs;
        xs = int'($urandom_range(0, 255));
        y = ((a * xs * xs) + (b * xs) + c) % 256;
      end else begin
        y = int'($urandom_range(0, 255));
      end
      do_search("random", a, b, c, y, int'($urandom_range(1, 4)), 1, n % 3 == 0);
    end
  endtask

  task automatic test_reset_mid_search();
    load_op(8'd0, 1, 0);
    load_op(8'd0, 1, 0);
    load_op(8'd0, 1, 0);
    load_op(8'd1, 1, 0);
    @(posedge clk);  // INIT entry
    repeat (101) @(posedge clk);  // candidate x = 100 now under test
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_search_busy got busy=%b done=%b want 1 0", busy, done);
    end
    resetn = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_mid_search");
    resetn = 1'b1;
    exp_done_hold = 1'b0;
    do_search("after_reset", 1, 2, 3, 11, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_wrap();
    test_handshake();
    test_random();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
